// File: rtl/alu_pkg.sv
// Shared definitions for the ALU share arbiter: widths, opcodes and FSM encoding.
package alu_pkg;

  localparam int OP_W   = 6;
  localparam int DATA_W = 32;

  localparam logic [OP_W-1:0] OP_ADD  = 6'h00;
  localparam logic [OP_W-1:0] OP_SUB  = 6'h01;
  localparam logic [OP_W-1:0] OP_AND  = 6'h02;
  localparam logic [OP_W-1:0] OP_OR   = 6'h03;
  localparam logic [OP_W-1:0] OP_SLT  = 6'h04;
  localparam logic [OP_W-1:0] OP_MUL  = 6'h05;
  localparam logic [OP_W-1:0] ALU_NOP = 6'h3F;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CAPT  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return op <= OP_MUL;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr wins, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  localparam logic [ID_W:0] NUM_REQ_EXT = (ID_W+1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [NUM_REQ-1:0]   rot_first;
  logic [ID_W-1:0]      off_acc [NUM_REQ+1];
  logic [ID_W:0]        idx_sum;

  // Rotate so the pointer position lands at bit 0, then isolate the lowest set bit.
  assign req_dbl   = {req, req} >> ptr;
  assign req_rot   = req_dbl[NUM_REQ-1:0];
  assign rot_first = req_rot & (~req_rot + 1'b1);

  assign off_acc[0] = '0;
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_off
    assign off_acc[gi+1] = off_acc[gi] | ({ID_W{rot_first[gi]}} & ID_W'(gi));
  end

  assign idx_sum   = {1'b0, ptr} + {1'b0, off_acc[NUM_REQ]};
  assign grant_idx = (idx_sum >= NUM_REQ_EXT) ? ID_W'(idx_sum - NUM_REQ_EXT) : idx_sum[ID_W-1:0];
  assign grant_any = |req;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
    assign grant[gi] = grant_any && (grant_idx == ID_W'(gi));
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one two-load ALU among NUM_REQ requesters with round-robin arbitration.
// Optional macro ALU_ARB_OPCHK_EN: illegal opcodes bypass the ALU and answer with resp_err.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [OP_W*NUM_REQ-1:0]   req_op,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_err,
  output logic                      alu_load,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [OP_W-1:0]           alu_op,
  input  logic [DATA_W-1:0]         alu_result
);

  state_e              state_reg, state_next;
  logic [ID_W-1:0]     ptr_reg;
  logic [OP_W-1:0]     op_reg;
  logic [DATA_W-1:0]   a_reg, b_reg;
  logic [ID_W-1:0]     id_reg;
  logic [DATA_W-1:0]   resp_data_reg;
  logic [ID_W-1:0]     resp_id_reg;

  logic [OP_W-1:0]     op_arr [NUM_REQ];
  logic [DATA_W-1:0]   a_arr  [NUM_REQ];
  logic [DATA_W-1:0]   b_arr  [NUM_REQ];

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_any;
  logic                accept;
  logic                sel_illegal;
  logic [OP_W-1:0]     sel_op;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign op_arr[gi] = req_op[gi*OP_W +: OP_W];
    assign a_arr[gi]  = req_a[gi*DATA_W +: DATA_W];
    assign b_arr[gi]  = req_b[gi*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign sel_op = op_arr[grant_idx];
  assign accept = (state_reg == ST_IDLE) && grant_any && rst_n;

`ifdef ALU_ARB_OPCHK_EN
  assign sel_illegal = !op_is_legal(sel_op);
`else
  assign sel_illegal = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    resp_valid = 1'b0;
    alu_load   = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_op     = '0;
    case (state_reg)
      ST_IDLE: begin
        // Gate with rst_n so the grant is not visible while reset is held.
        if (rst_n) req_ready = grant;
        if (grant_any) state_next = sel_illegal ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: begin
        alu_load   = 1'b1;
        alu_a      = a_reg;
        alu_b      = b_reg;
        alu_op     = op_reg;
        state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Second load pushes a NOP; the ALU evaluates the captured operation here.
        alu_load   = 1'b1;
        alu_op     = ALU_NOP;
        state_next = ST_CAPT;
      end
      ST_CAPT: begin
        state_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= '0;
      op_reg        <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      id_reg        <= '0;
      resp_data_reg <= '0;
      resp_id_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg <= sel_op;
        a_reg  <= a_arr[grant_idx];
        b_reg  <= b_arr[grant_idx];
        id_reg <= grant_idx;
      end
      if (accept && sel_illegal) begin
        resp_data_reg <= '0;
        resp_id_reg   <= grant_idx;
      end
      if (state_reg == ST_CAPT) begin
        resp_data_reg <= alu_result;
        resp_id_reg   <= id_reg;
      end
      if (state_reg == ST_RESP && resp_ready) begin
        ptr_reg <= (id_reg == ID_W'(NUM_REQ-1)) ? '0 : id_reg + 1'b1;
      end
    end
  end

`ifdef ALU_ARB_OPCHK_EN
  logic resp_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_err_reg <= 1'b0;
    end else if (accept) begin
      resp_err_reg <= sel_illegal;
    end
  end

  assign resp_err = resp_err_reg;
`else
  assign resp_err = 1'b0;
`endif

  assign resp_data = resp_data_reg;
  assign resp_id   = resp_id_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural two-load ALU attached.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [6*NUM_REQ-1:0] req_op;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [ID_W-1:0]      resp_id;
  logic [31:0]          resp_data;
  logic                 resp_err;
  logic                 alu_load;
  logic [31:0]          alu_a;
  logic [31:0]          alu_b;
  logic [5:0]           alu_op;
  logic [31:0]          alu_result;

  logic [5:0]  op_v [NUM_REQ];
  logic [31:0] a_v  [NUM_REQ];
  logic [31:0] b_v  [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_flat
    assign req_op[gi*6 +: 6]   = op_v[gi];
    assign req_a[gi*32 +: 32]  = a_v[gi];
    assign req_b[gi*32 +: 32]  = b_v[gi];
  end

  alu_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .alu_load   (alu_load),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_MUL:  return a * b;
      default: return 32'd0;
    endcase
  endfunction

  // Behavioural ALU: each load latches operands and evaluates the previously latched ones.
  logic [5:0]  alu_op_l;
  logic [31:0] alu_a_l, alu_b_l, alu_res;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op_l <= '0;
      alu_a_l  <= '0;
      alu_b_l  <= '0;
      alu_res  <= '0;
    end else if (alu_load) begin
      alu_res  <= alu_ref(alu_op_l, alu_a_l, alu_b_l);
      alu_op_l <= alu_op;
      alu_a_l  <= alu_a;
      alu_b_l  <= alu_b;
    end
  end
  assign alu_result = alu_res;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
    logic            err;
    int              cyc;
    int              lat;
  } exp_t;

  exp_t            sb[$];
  logic [ID_W-1:0] ids_log[$];
  int              tests_run = 0;
  int              tests_failed = 0;
  int              cycle = 0;
  int              load_cnt = 0;
  logic            resp_seen = 1'b0;
  logic [31:0]     last_data;
  logic            last_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  task automatic drive_req(input logic [1:0] i, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    op_v[i] = op;
    a_v[i]  = a;
    b_v[i]  = b;
    req_valid[i] = 1'b1;
  endtask

  // One clock: sample at negedge (scoreboard push/pop), then drop accepted requests after posedge.
  task automatic tick();
    logic [NUM_REQ-1:0] acc;
    logic [1:0]         idx;
    exp_t               e;
    @(negedge clk);
    cycle++;
    if (alu_load) load_cnt++;
    acc = req_valid & req_ready;
    check_val("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = 2'(k);
      if (acc[idx]) begin
        e.id  = idx;
        e.cyc = cycle;
`ifdef ALU_ARB_OPCHK_EN
        if (op_v[idx] > OP_MUL) begin
          e.data = 32'd0;
          e.err  = 1'b1;
          e.lat  = 1;
        end else begin
          e.data = alu_ref(op_v[idx], a_v[idx], b_v[idx]);
          e.err  = 1'b0;
          e.lat  = 4;
        end
`else
        e.data = alu_ref(op_v[idx], a_v[idx], b_v[idx]);
        e.err  = 1'b0;
        e.lat  = 4;
`endif
        sb.push_back(e);
        $display("[TB] accept id=%0d op=%0h a=%0h b=%0h exp=%0h cycle=%0d", idx, op_v[idx], a_v[idx], b_v[idx], e.data, cycle);
      end
    end
    if (resp_valid) begin
      if (sb.size() == 0) begin
        check_val("unexpected_resp", 32'(resp_valid), 32'd0);
      end else begin
        if (!resp_seen) begin
          check_val("latency", 32'(cycle - sb[0].cyc), 32'(sb[0].lat));
          resp_seen = 1'b1;
        end
        if (resp_ready) begin
          check_val("resp_id", 32'(resp_id), 32'(sb[0].id));
          check_val("resp_data", resp_data, sb[0].data);
          check_val("resp_err", 32'(resp_err), 32'(sb[0].err));
          $display("[TB] resp id=%0d data=%0h err=%0d cycle=%0d", resp_id, resp_data, resp_err, cycle);
          ids_log.push_back(resp_id);
          last_data = resp_data;
          last_err  = resp_err;
          void'(sb.pop_front());
          resp_seen = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || req_valid != '0) && n < budget) begin
      tick();
      n++;
    end
    check_val("drain_in_budget", 32'(n < budget), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n      = 1'b0;
    resp_ready = 1'b1;
    req_valid  = '1;
    for (int k = 0; k < NUM_REQ; k++) begin
      op_v[k] = '0;
      a_v[k]  = '0;
      b_v[k]  = '0;
    end
    #3;
    check_val("rst_req_ready", 32'(req_ready), 32'd0);
    check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_val("rst_alu_load", 32'(alu_load), 32'd0);
    check_val("rst_resp_data", resp_data, 32'd0);
    req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // All four at once from pointer 0, then requester 2 alone.
    ids_log.delete();
    drive_req(2'd0, OP_ADD, 32'd1, 32'd2);
    drive_req(2'd1, OP_SUB, 32'd10, 32'd3);
    drive_req(2'd2, OP_AND, 32'hF0F0, 32'hFF00);
    drive_req(2'd3, OP_MUL, 32'd6, 32'd7);
    run_until_idle(60);
    check_val("order_count", 32'(ids_log.size()), 32'd4);
    for (int k = 0; k < 4 && k < ids_log.size(); k++) check_val("order_id", 32'(ids_log[k]), 32'(k));
    drive_req(2'd2, OP_OR, 32'd1, 32'd4);
    run_until_idle(20);
    check_val("single_req2_id", 32'(ids_log[ids_log.size()-1]), 32'd2);
    check_val("single_req2_data", last_data, 32'd5);

    // Basic ADD with latency checked by the scoreboard.
    drive_req(2'd0, OP_ADD, 32'd5, 32'd7);
    run_until_idle(20);
    check_val("add_5_7", last_data, 32'd12);

    // Response backpressure: outputs hold, no grants while stalled.
    resp_ready = 1'b0;
    drive_req(2'd1, OP_SUB, 32'd100, 32'd1);
    drive_req(2'd3, OP_ADD, 32'd8, 32'd8);
    n = 0;
    while (!resp_valid && n < 10) begin
      tick();
      n++;
    end
    check_val("stall_resp_seen", 32'(resp_valid), 32'd1);
    if (sb.size() != 0) begin
      for (int k = 0; k < 10; k++) begin
        tick();
        check_val("stall_valid", 32'(resp_valid), 32'd1);
        check_val("stall_data", resp_data, sb[0].data);
        check_val("stall_id", 32'(resp_id), 32'(sb[0].id));
        check_val("stall_ready", 32'(req_ready), 32'd0);
      end
    end
    n = ids_log.size();
    resp_ready = 1'b1;
    tick();
    check_val("stall_one_hs", 32'(ids_log.size() - n), 32'd1);
    check_val("stall_valid_drop", 32'(resp_valid), 32'd0);
    run_until_idle(30);

    // Arithmetic corner cases.
    drive_req(2'd0, OP_SLT, 32'hFFFF_FFFD, 32'd2);
    run_until_idle(20);
    check_val("slt_m3_2", last_data, 32'd1);
    drive_req(2'd1, OP_SUB, 32'd0, 32'd1);
    run_until_idle(20);
    check_val("sub_0_1", last_data, 32'hFFFF_FFFF);
    drive_req(2'd2, OP_MUL, 32'h0001_0000, 32'h0001_0000);
    run_until_idle(20);
    check_val("mul_wrap", last_data, 32'd0);
    drive_req(2'd3, OP_OR, 32'h5, 32'hA);
    run_until_idle(20);
    check_val("or_5_a", last_data, 32'hF);

    // Illegal opcode.
    load_cnt = 0;
    drive_req(2'd3, 6'h20, 32'd9, 32'd9);
    run_until_idle(20);
    check_val("illegal_data", last_data, 32'd0);
`ifdef ALU_ARB_OPCHK_EN
    check_val("illegal_err", 32'(last_err), 32'd1);
    check_val("illegal_no_load", 32'(load_cnt), 32'd0);
`else
    check_val("illegal_err", 32'(last_err), 32'd0);
    check_val("illegal_loads", 32'(load_cnt), 32'd2);
`endif

    // Reset during DRAIN aborts the operation.
    drive_req(2'd1, OP_ADD, 32'd3, 32'd4);
    n = 0;
    while (sb.size() == 0 && n < 10) begin
      tick();
      n++;
    end
    check_val("abort_accepted", 32'(sb.size()), 32'd1);
    tick();
    check_val("in_drain_load", 32'(alu_load), 32'd1);
    check_val("in_drain_op", 32'(alu_op), 32'(ALU_NOP));
    rst_n = 1'b0;
    sb.delete();
    resp_seen = 1'b0;
    #1;
    check_val("abort_resp_valid", 32'(resp_valid), 32'd0);
    check_val("abort_alu_load", 32'(alu_load), 32'd0);
    check_val("abort_alu_op", 32'(alu_op), 32'd0);
    check_val("abort_resp_data", resp_data, 32'd0);
    check_val("abort_resp_id", 32'(resp_id), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_val("abort_no_resp", 32'(resp_valid), 32'd0);
    end
    drive_req(2'd0, OP_ADD, 32'd1, 32'd1);
    run_until_idle(20);
    check_val("post_reset_add", last_data, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
